tx_8b10b_ctrl: RTL

Transmit-side link controller that drives the existing combinational `encode` 8b/10b encoder. It owns the running disparity and sequences the line through reset, comma alignment and data run. It inserts K28.5 idles when no data is offered and forces periodic K28.5 commas for receiver alignment and clock compensation. It sits between the byte-stream source and the serializer and produces one registered 10-bit symbol per clock.

---
 rtl/pkg_8b10b.sv | 21 ++
 rtl/encode.sv | 87 ++++++++
 rtl/tx_8b10b_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pkg_8b10b.sv
// Shared definitions for the 8b/10b transmit path: comma code, line-state
// enum and the legal control-character check.
package pkg_8b10b;

    localparam logic [8:0] K28_5 = 9'h1BC;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    function automatic logic is_legal_k(input logic [7:0] b);
        case (b)
            8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
            8'hF7, 8'hFB, 8'hFD, 8'hFE: is_legal_k = 1'b1;
            default:                    is_legal_k = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/encode.sv
// Combinational 8b/10b encoder. datain = {K, HGFEDCBA}; dataout bit 0 is
// line bit 'a', bit 9 is 'j' ({j,h,g,f,i,e,d,c,b,a}).
module encode (
    input  logic [8:0] datain,
    input  logic       dispin,
    output logic [9:0] dataout,
    output logic       dispout
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k;
    logic       k28;
    logic [5:0] c6_neg;
    logic [5:0] c6;
    logic [3:0] c4_neg;
    logic [3:0] c4;
    logic       unbal6;
    logic       flip6;
    logic       flip4;
    logic       rd6;
    logic       use_a7;

    function automatic logic [2:0] ones6(input logic [5:0] v);
        ones6 = '0;
        for (int i = 0; i < 6; i++) ones6 = ones6 + {2'b00, v[i]};
    endfunction

    assign x   = datain[4:0];
    assign y   = datain[7:5];
    assign k   = datain[8];
    assign k28 = k && (x == 5'd28);

    // 5b/6b codes in the RD- column, written abcdei with 'a' as MSB
    always_comb begin
        case (x)
            5'd0:  c6_neg = 6'b100111;  5'd1:  c6_neg = 6'b011101;
            5'd2:  c6_neg = 6'b101101;  5'd3:  c6_neg = 6'b110001;
            5'd4:  c6_neg = 6'b110101;  5'd5:  c6_neg = 6'b101001;
            5'd6:  c6_neg = 6'b011001;  5'd7:  c6_neg = 6'b111000;
            5'd8:  c6_neg = 6'b111001;  5'd9:  c6_neg = 6'b100101;
            5'd10: c6_neg = 6'b010101;  5'd11: c6_neg = 6'b110100;
            5'd12: c6_neg = 6'b001101;  5'd13: c6_neg = 6'b101100;
            5'd14: c6_neg = 6'b011100;  5'd15: c6_neg = 6'b010111;
            5'd16: c6_neg = 6'b011011;  5'd17: c6_neg = 6'b100011;
            5'd18: c6_neg = 6'b010011;  5'd19: c6_neg = 6'b110010;
            5'd20: c6_neg = 6'b001011;  5'd21: c6_neg = 6'b101010;
            5'd22: c6_neg = 6'b011010;  5'd23: c6_neg = 6'b111010;
            5'd24: c6_neg = 6'b110011;  5'd25: c6_neg = 6'b100110;
            5'd26: c6_neg = 6'b010110;  5'd27: c6_neg = 6'b110110;
            5'd28: c6_neg = 6'b001110;  5'd29: c6_neg = 6'b101110;
            5'd30: c6_neg = 6'b011110;  default: c6_neg = 6'b101011;
        endcase
        if (k28) c6_neg = 6'b001111;
    end

    always_comb begin
        unbal6 = (ones6(c6_neg) != 3'd3);
        // D.07 is balanced but still has two forms
        flip6  = unbal6 || (x == 5'd7);
        c6     = (dispin && flip6) ? ~c6_neg : c6_neg;
        rd6    = unbal6 ? ~dispin : dispin;

        use_a7 = (y == 3'd7) &&
                 (k || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                       ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        case (y)
            3'd0:    c4_neg = 4'b1011;
            3'd1:    c4_neg = 4'b1001;
            3'd2:    c4_neg = 4'b0101;
            3'd3:    c4_neg = 4'b1100;
            3'd4:    c4_neg = 4'b1101;
            3'd5:    c4_neg = 4'b1010;
            3'd6:    c4_neg = 4'b0110;
            default: c4_neg = use_a7 ? 4'b0111 : 4'b1110;
        endcase
        flip4 = (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7);
        c4    = (rd6 && flip4) ? ~c4_neg : c4_neg;
        // K28 inverts its balanced 3b/4b codes after a negative 6b block
        if (k28 && !rd6 && !flip4) c4 = ~c4_neg;

        dispout = ((y == 3'd0) || (y == 3'd4) || (y == 3'd7)) ? ~rd6 : rd6;
        dataout = {c4[0], c4[1], c4[2], c4[3],
                   c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    end

endmodule

// File: rtl/tx_8b10b_ctrl.sv
// Transmit link controller: sequences RESET/ALIGN/RUN, inserts K28.5 idles
// and periodic commas, owns running disparity, registers one symbol per clock.
module tx_8b10b_ctrl
    import pkg_8b10b::*;
#(
    parameter int ALIGN_COUNT  = 16,
    parameter int COMMA_PERIOD = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_k,
    output logic       s_ready,
    input  logic       realign,
    output logic [9:0] tx_symbol,
    output logic       tx_valid,
    output logic       tx_is_data,
    output logic       rd,
    output logic       link_up,
    output logic       err_illegal_k
);

    localparam int AW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
    localparam int PW = $clog2(COMMA_PERIOD);
    localparam logic [AW-1:0] ALIGN_LAST  = AW'(ALIGN_COUNT - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(COMMA_PERIOD - 1);

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   align_cnt;
    logic [AW-1:0]   align_next;
    logic [PW-1:0]   period_cnt;
    logic [PW-1:0]   period_next;
    logic            force_comma;
    logic            accept;
    logic            illegal_k;
    logic            use_src;
    logic            emit;
    logic            sent_comma;
    logic [8:0]      enc_in;
    logic [9:0]      enc_out;
    logic            enc_disp;

    // s_valid/s_ready: a byte transfers on a rising edge where both are high;
    // s_ready depends only on registered state, never on s_valid or realign.
    always_comb begin
        force_comma = (state == RUN) && (period_cnt == PERIOD_LAST);
        s_ready     = (state == RUN) && !force_comma;
        accept      = s_valid && s_ready;
        illegal_k   = accept && s_k && !is_legal_k(s_data);
        use_src     = accept && !illegal_k;
        enc_in      = use_src ? {s_k, s_data} : K28_5;
        emit        = (state != RESET);
        sent_comma  = (enc_in == K28_5);
    end

    encode u_encode (
        .datain  (enc_in),
        .dispin  (rd),
        .dataout (enc_out),
        .dispout (enc_disp)
    );

    always_comb begin
        next_state = state;
        align_next = align_cnt;
        case (state)
            RESET: begin
                next_state = ALIGN;
                align_next = '0;
            end
            ALIGN: begin
                if (realign) begin
                    align_next = '0;
                end else if (align_cnt == ALIGN_LAST) begin
                    next_state = RUN;
                end else begin
                    align_next = align_cnt + 1'b1;
                end
            end
            RUN: begin
                if (realign) begin
                    next_state = ALIGN;
                    align_next = '0;
                end
            end
            default: next_state = RESET;
        endcase

        // Any K28.5 on the line restarts the spacing count
        period_next = period_cnt;
        if (emit) period_next = sent_comma ? '0 : period_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET;
            align_cnt  <= '0;
            period_cnt <= '0;
        end else begin
            state      <= next_state;
            align_cnt  <= align_next;
            period_cnt <= period_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_symbol     <= '0;
            tx_valid      <= 1'b0;
            tx_is_data    <= 1'b0;
            rd            <= 1'b0;
            link_up       <= 1'b0;
            err_illegal_k <= 1'b0;
        end else if (emit) begin
            tx_symbol     <= enc_out;
            tx_valid      <= 1'b1;
            tx_is_data    <= use_src;
            rd            <= enc_disp;
            link_up       <= (state == RUN);
            err_illegal_k <= illegal_k;
        end
    end

endmodule
